// File: rtl/fpmul_arb.sv
// Round-robin sequencer sharing one fpmul core among N_REQ requesters, with a
// tag pipeline matched to MUL_LAT. Define FPMUL_ARB_FIXED_PRIO_EN for fixed priority.
module fpmul_arb #(
    parameter int N_REQ   = 4,
    parameter int MUL_LAT = 0,
    localparam int IDW    = $clog2(N_REQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_REQ-1:0]     req_valid,
    input  logic [N_REQ*32-1:0]  req_a,
    input  logic [N_REQ*32-1:0]  req_b,
    output logic [N_REQ-1:0]     req_ready,
    output logic [31:0]          mul_a,
    output logic [31:0]          mul_b,
    output logic                 mul_vld,
    input  logic [31:0]          mul_c,
    input  logic                 mul_omu,
    output logic                 rsp_valid,
    output logic [IDW-1:0]       rsp_id,
    output logic [31:0]          rsp_c,
    output logic                 rsp_omu
);

    logic [N_REQ-1:0][31:0] a_arr;
    logic [N_REQ-1:0][31:0] b_arr;
    logic [IDW-1:0]         gnt_id;
    logic                   any;
    logic                   accept;

    assign a_arr = req_a;
    assign b_arr = req_b;

`ifdef FPMUL_ARB_FIXED_PRIO_EN
    always_comb begin
        gnt_id = '0;
        any    = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (!any && req_valid[i]) begin
                any    = 1'b1;
                gnt_id = IDW'(i);
            end
        end
    end
`else
    logic [IDW-1:0] rr_ptr;
    logic [IDW-1:0] cand;

    // Search starts one past the last winner so the last winner ranks lowest.
    always_comb begin
        gnt_id = '0;
        any    = 1'b0;
        cand   = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand = IDW'((int'(rr_ptr) + k) % N_REQ);
            if (!any && req_valid[cand]) begin
                any    = 1'b1;
                gnt_id = cand;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            rr_ptr <= IDW'(N_REQ - 1);
        else if (accept)
            rr_ptr <= gnt_id;
    end
`endif

    assign req_ready = (any && !rst) ? (N_REQ'(1) << gnt_id) : '0;
    assign accept    = |req_ready;

    // vld_pipe[0]/id_pipe[0] is the issue stage; [MUL_LAT] is the tail.
    logic [MUL_LAT:0]          vld_pipe;
    logic [MUL_LAT:0][IDW-1:0] id_pipe;

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe <= '0;
            id_pipe  <= '0;
            mul_a    <= '0;
            mul_b    <= '0;
        end else begin
            vld_pipe[0] <= accept;
            if (accept) begin
                id_pipe[0] <= gnt_id;
                mul_a      <= a_arr[gnt_id];
                mul_b      <= b_arr[gnt_id];
            end
            for (int s = 1; s <= MUL_LAT; s++) begin
                vld_pipe[s] <= vld_pipe[s-1];
                id_pipe[s]  <= id_pipe[s-1];
            end
        end
    end

    assign mul_vld = vld_pipe[0];

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_c     <= '0;
            rsp_omu   <= 1'b0;
        end else begin
            rsp_valid <= vld_pipe[MUL_LAT];
            if (vld_pipe[MUL_LAT]) begin
                rsp_id  <= id_pipe[MUL_LAT];
                rsp_c   <= mul_c;
                rsp_omu <= mul_omu;
            end
        end
    end

endmodule
